cpu_bus_arbiter: RTL and testbench
==================================

# cpu_bus_arbiter

Two-master, one-slave arbiter that shares the single CPU memory bus between the instruction-fetch port and the data (MEM-stage) port. It forwards exactly one master's request per cycle and holds that grant across slave wait states until the transaction completes. It returns read data and per-master stall. A starvation counter guarantees fetch progress under sustained data traffic. It sits between the pipeline's two bus masters and the downstream memory/MMU bus.

## Interface

- STARVE_LIMIT, default 4: consecutive completed data transactions allowed while fetch waits; after that, fetch wins the next arbitration. A value of 0 selects pure data priority.

- clk  input  1  core clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset (low = in reset)
- inst_bus  Bus_if.slave  -  fetch master: read, write, address[31:0], data_wr[31:0], mask[3:0] in; data_rd[31:0], stall out
- data_bus  Bus_if.slave  -  data master, same fields as inst_bus
- mem_bus  Bus_if.master  -  downstream slave, same fields with directions reversed
- grant  output  2  current owner: 2'b00 none, 2'b01 inst, 2'b10 data

## Operation

- Request: a master requests when read|write = 1. A transaction completes in a cycle where the owner's read|write = 1 and mem_bus.stall = 0. mem_bus.data_rd is valid in that cycle.
- The state machine has three states: IDLE, LOCK_I and LOCK_D.
- IDLE:
  - Winner is chosen combinationally in the same cycle, with no added latency.
  - Data wins over fetch, except when starve_cnt == STARVE_LIMIT and STARVE_LIMIT != 0, in which case fetch wins.
  - If there is no request, grant = 00.
  - If the winner's transaction stalls (mem_bus.stall = 1), the next state is LOCK_I or LOCK_D; otherwise the state stays IDLE.
- LOCK_x:
  - Owner x is forwarded unconditionally, and the other request is ignored.
  - Exit to IDLE in the cycle the transaction completes (mem_bus.stall = 0).
  - The owner must hold its request fields stable while stalled.
  - If the owner drops its request while locked, forward the all-zero request and return to IDLE next cycle.
- Forwarding: mem_bus.{read, write, address, data_wr, mask} equal the owner's fields. With no owner, all are zero.
- Read data: mem_bus.data_rd is broadcast to both inst_bus.data_rd and data_bus.data_rd. Each master samples it only when its own stall = 0.
- Stall, per master:
  - Owner: equals mem_bus.stall.
  - Requesting non-owner: 1.
  - Non-requesting: 0.
- Starvation counter (starve_cnt, width $clog2(STARVE_LIMIT+1)):
  - Increments, saturating at STARVE_LIMIT, on each completed data transaction while inst_bus.read = 1.
  - Clears to 0 when a fetch transaction completes, or in any cycle with inst_bus.read = 0.
- Simultaneous events: when a completion and a new request fall in the same cycle, the new request is arbitrated in the following cycle from IDLE. An owner never issues back-to-back transactions without re-arbitrating.

## Timing

- Reset, rst low, effective immediately and asynchronously:
  - State is IDLE and starve_cnt = 0.
  - grant = 00.
  - All mem_bus outputs are 0.
  - inst_bus.stall = data_bus.stall = 0.
  - data_rd outputs are 0.
- Reset mid-transaction abandons the transaction. After release, arbitration restarts from IDLE on the first edge.
- A zero-wait-state slave gives a same-cycle grant and completion: 1 transaction per cycle, with fetch and data alternating only under the starvation rule.
- A slave stall of N cycles keeps the grant for N+1 cycles. The non-owner's stall stays high for the whole window.
- grant, the stalls and the mem_bus outputs are combinational from state, requests and mem_bus.stall. state and starve_cnt are registered.

## Test plan

- Reset: hold rst=0 with both masters requesting -> grant=00, mem_bus.read=0, both stalls 0. Release rst -> data granted the same cycle.
- Single fetch, zero-wait: inst read at address 0xBFC00000, mask 1111 -> mem_bus.address=0xBFC00000 that cycle, inst_bus.stall=0, inst_bus.data_rd equals the slave value.
- Contention with slave stall=2: both masters request -> data owns for 3 cycles (LOCK_D), inst_bus.stall=1 throughout. Inst is granted the cycle after data completes.
- Starvation, STARVE_LIMIT=4: continuous data writes plus a pending fetch, zero-wait slave -> 4 data completions, then 1 fetch. starve_cnt returns to 0.
- Owner drops request in LOCK_I (slave stalling) -> mem_bus.read=0 that cycle, state IDLE next cycle, pending data granted.
- Async reset asserted mid-LOCK_D -> outputs zero immediately, without waiting for a clock edge. The next transaction after release starts from IDLE.

Source files
------------

// File: rtl/cpu_bus_arbiter_if.sv
// Simple CPU memory bus: one request per cycle, slave extends it with stall.
// The master modport drives the request fields; the slave modport returns data and stall.
interface Bus_if;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] data_wr;
  logic [3:0]  mask;
  logic [31:0] data_rd;
  logic        stall;

  modport master (
    output read, write, address, data_wr, mask,
    input  data_rd, stall
  );

  modport slave (
    input  read, write, address, data_wr, mask,
    output data_rd, stall
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Shares one memory bus between the fetch and data masters, holding the grant across
// slave wait states, with a starvation counter that guarantees fetch progress.
module cpu_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  Bus_if.slave       inst_bus,
  Bus_if.slave       data_bus,
  Bus_if.master      mem_bus,
  output logic [1:0] grant
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             inst_req, data_req, fetch_pri;
  logic             own_i, own_d;
  logic             fwd_i, fwd_d;
  logic             done_i, done_d;

  assign inst_req  = inst_bus.read | inst_bus.write;
  assign data_req  = data_bus.read | data_bus.write;
  assign fetch_pri = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    own_i     = 1'b0;
    own_d     = 1'b0;
    case (state)
      IDLE: begin
        // Data normally wins; fetch wins only once data has used up its starvation budget.
        if (inst_req && (fetch_pri || !data_req)) own_i = 1'b1;
        else if (data_req)                        own_d = 1'b1;
        if (own_i && mem_bus.stall) state_nxt = LOCK_I;
        if (own_d && mem_bus.stall) state_nxt = LOCK_D;
      end
      LOCK_I: begin
        own_i = 1'b1;
        if (!inst_req || !mem_bus.stall) state_nxt = IDLE;
      end
      LOCK_D: begin
        own_d = 1'b1;
        if (!data_req || !mem_bus.stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset must silence every output immediately, even before the state register settles.
    if (!rst) begin
      own_i = 1'b0;
      own_d = 1'b0;
    end
  end

  // An owner that has dropped its request is forwarded as an all-zero request.
  assign fwd_i  = own_i & inst_req;
  assign fwd_d  = own_d & data_req;
  assign done_i = fwd_i & ~mem_bus.stall;
  assign done_d = fwd_d & ~mem_bus.stall;

  assign grant = {own_d, own_i};

  assign mem_bus.read    = (fwd_i & inst_bus.read)  | (fwd_d & data_bus.read);
  assign mem_bus.write   = (fwd_i & inst_bus.write) | (fwd_d & data_bus.write);
  assign mem_bus.address = ({32{fwd_i}} & inst_bus.address) | ({32{fwd_d}} & data_bus.address);
  assign mem_bus.data_wr = ({32{fwd_i}} & inst_bus.data_wr) | ({32{fwd_d}} & data_bus.data_wr);
  assign mem_bus.mask    = ({4{fwd_i}}  & inst_bus.mask)    | ({4{fwd_d}}  & data_bus.mask);

  // Requesting non-owners wait; the owner sees the slave's wait state.
  assign inst_bus.stall = rst & inst_req & (~fwd_i | mem_bus.stall);
  assign data_bus.stall = rst & data_req & (~fwd_d | mem_bus.stall);

  assign inst_bus.data_rd = rst ? mem_bus.data_rd : 32'd0;
  assign data_bus.data_rd = rst ? mem_bus.data_rd : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             starve_cnt <= '0;
    else if (!inst_bus.read || done_i)    starve_cnt <= '0;
    else if (done_d && starve_cnt != LIMIT) starve_cnt <= starve_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: reset, zero-wait fetch, contention with wait
// states, starvation rotation, owner drop while locked and async reset mid-lock.
module tb_cpu_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  int         errors = 0;
  int         checks = 0;

  Bus_if inst_if();
  Bus_if data_if();
  Bus_if mem_if();

  cpu_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .inst_bus (inst_if.slave),
    .data_bus (data_if.slave),
    .mem_bus  (mem_if.master),
    .grant    (grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] starve_exp [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

  initial begin
    rst = 1'b1;
    inst_if.read = 0; inst_if.write = 0; inst_if.address = 0; inst_if.data_wr = 0; inst_if.mask = 0;
    data_if.read = 0; data_if.write = 0; data_if.address = 0; data_if.data_wr = 0; data_if.mask = 0;
    mem_if.stall = 0; mem_if.data_rd = 0;
    #1 rst = 1'b0;

    // Reset held with both masters requesting
    inst_if.read = 1; inst_if.address = 32'hBFC00000; inst_if.mask = 4'hF;
    data_if.read = 1; data_if.address = 32'h10000000; data_if.mask = 4'hF;
    mem_if.data_rd = 32'hDEADBEEF;
    tick(); tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_mem_read", 32'(mem_if.read), 32'h0);
    check("rst_mem_addr", mem_if.address, 32'h0);
    check("rst_inst_stall", 32'(inst_if.stall), 32'h0);
    check("rst_data_stall", 32'(data_if.stall), 32'h0);
    check("rst_data_rd", data_if.data_rd, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("rel_grant", 32'(grant), 32'h2);
    check("rel_mem_addr", mem_if.address, 32'h10000000);
    check("rel_inst_stall", 32'(inst_if.stall), 32'h1);
    check("rel_data_stall", 32'(data_if.stall), 32'h0);
    check("rel_data_rd", data_if.data_rd, 32'hDEADBEEF);
    tick();
    inst_if.read = 0; data_if.read = 0;
    tick();

    // Single zero-wait fetch
    inst_if.read = 1; mem_if.data_rd = 32'h3C080000;
    #1;
    check("fetch_grant", 32'(grant), 32'h1);
    check("fetch_addr", mem_if.address, 32'hBFC00000);
    check("fetch_read", 32'(mem_if.read), 32'h1);
    check("fetch_mask", 32'(mem_if.mask), 32'hF);
    check("fetch_stall", 32'(inst_if.stall), 32'h0);
    check("fetch_rd", inst_if.data_rd, 32'h3C080000);
    tick();
    inst_if.read = 0;
    tick();

    // Contention, slave stalls two cycles
    inst_if.read = 1; data_if.read = 1; data_if.address = 32'h00000020; mem_if.stall = 1;
    #1;
    check("cont0_grant", 32'(grant), 32'h2);
    check("cont0_inst_stall", 32'(inst_if.stall), 32'h1);
    check("cont0_data_stall", 32'(data_if.stall), 32'h1);
    check("cont0_addr", mem_if.address, 32'h00000020);
    tick();
    check("cont1_grant", 32'(grant), 32'h2);
    check("cont1_inst_stall", 32'(inst_if.stall), 32'h1);
    tick();
    mem_if.stall = 0;
    #1;
    check("cont2_grant", 32'(grant), 32'h2);
    check("cont2_data_stall", 32'(data_if.stall), 32'h0);
    check("cont2_inst_stall", 32'(inst_if.stall), 32'h1);
    tick();
    data_if.read = 0;
    #1;
    check("cont3_grant", 32'(grant), 32'h1);
    check("cont3_addr", mem_if.address, 32'hBFC00000);
    check("cont3_inst_stall", 32'(inst_if.stall), 32'h0);
    tick();
    inst_if.read = 0;
    tick();

    // Starvation rotation: four data writes, then the waiting fetch
    data_if.write = 1; data_if.address = 32'h00000030; data_if.data_wr = 32'h0000A5A5;
    inst_if.read = 1;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("starve_grant%0d", i), 32'(grant), 32'(starve_exp[i]));
      if (i == 5) check("starve_cnt_clear", 32'(dut.starve_cnt), 32'h0);
      if (starve_exp[i] == 2'b10) check($sformatf("starve_wdata%0d", i), mem_if.data_wr, 32'h0000A5A5);
      tick();
    end
    data_if.write = 0; inst_if.read = 0;
    tick();

    // Owner drops its request while locked
    inst_if.read = 1; mem_if.stall = 1;
    #1;
    check("drop0_grant", 32'(grant), 32'h1);
    tick();
    data_if.read = 1; data_if.address = 32'h00000040;
    #1;
    check("drop1_grant", 32'(grant), 32'h1);
    check("drop1_data_stall", 32'(data_if.stall), 32'h1);
    check("drop1_addr", mem_if.address, 32'hBFC00000);
    tick();
    inst_if.read = 0;
    #1;
    check("drop2_mem_read", 32'(mem_if.read), 32'h0);
    check("drop2_addr", mem_if.address, 32'h0);
    check("drop2_inst_stall", 32'(inst_if.stall), 32'h0);
    check("drop2_data_stall", 32'(data_if.stall), 32'h1);
    tick();
    mem_if.stall = 0;
    #1;
    check("drop3_grant", 32'(grant), 32'h2);
    check("drop3_addr", mem_if.address, 32'h00000040);
    check("drop3_data_stall", 32'(data_if.stall), 32'h0);
    tick();
    data_if.read = 0;
    tick();

    // Async reset in the middle of a locked data transaction
    data_if.read = 1; mem_if.stall = 1;
    #1;
    check("arst0_grant", 32'(grant), 32'h2);
    tick();
    check("arst1_grant", 32'(grant), 32'h2);
    #2 rst = 1'b0;
    #1;
    check("arst_grant", 32'(grant), 32'h0);
    check("arst_mem_read", 32'(mem_if.read), 32'h0);
    check("arst_mem_addr", mem_if.address, 32'h0);
    check("arst_data_stall", 32'(data_if.stall), 32'h0);
    check("arst_data_rd", data_if.data_rd, 32'h0);
    data_if.read = 0; inst_if.read = 1; mem_if.stall = 0;
    #1 rst = 1'b1;
    #1;
    check("arst_rel_grant", 32'(grant), 32'h1);
    check("arst_rel_addr", mem_if.address, 32'hBFC00000);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
